// File: rtl/sinhron_marker_gen_pkg.sv
// Shared definitions for the frame/cycle marker generator and its consumers.
package sinhron_pkg;

   // Default counter widths
   localparam int unsigned TICK_W_DEF = 16;
   localparam int unsigned CYC_W_DEF  = 8;

   // Generator control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2
   } sinhron_state_e;

   // Marker bit positions, also used by the TST test-signal selector
   localparam int unsigned MRK_TNO  = 0;
   localparam int unsigned MRK_TNC  = 1;
   localparam int unsigned MRK_TNI  = 2;
   localparam int unsigned MRK_TKI  = 3;
   localparam int unsigned MRK_TNP  = 4;
   localparam int unsigned MRK_TKP  = 5;
   localparam int unsigned MRK_TOBM = 6;
   localparam int unsigned MRK_NUM  = 7;

endpackage

// File: rtl/sinhron_marker_gen_if.sv
// Configuration inputs and marker outputs of the marker generator.
interface sinhron_marker_gen_if
   import sinhron_pkg::*;
#(
   parameter int unsigned TICK_W = TICK_W_DEF,
   parameter int unsigned CYC_W  = CYC_W_DEF
);
   logic [TICK_W-1:0] cyc_len;
   logic [CYC_W-1:0]  n_cyc;
   logic [TICK_W-1:0] ti_start;
   logic [TICK_W-1:0] ti_end;
   logic [TICK_W-1:0] rp_start;
   logic [TICK_W-1:0] rp_end;

   logic TNO;
   logic TNC;
   logic TNI;
   logic TKI;
   logic TNP;
   logic TKP;
   logic TOBM;
   logic running;
   logic sync_err;

   // Generator side
   modport master (
      input  cyc_len, n_cyc, ti_start, ti_end, rp_start, rp_end,
      output TNO, TNC, TNI, TKI, TNP, TKP, TOBM, running, sync_err
   );

   // Configuring / consuming side
   modport slave (
      output cyc_len, n_cyc, ti_start, ti_end, rp_start, rp_end,
      input  TNO, TNC, TNI, TKI, TNP, TKP, TOBM, running, sync_err
   );
endinterface

// File: rtl/sinhron_marker_gen_sync_edge.sv
// Two-flop synchroniser for an asynchronous strobe plus rising-edge detect.
module sinhron_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);
   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;

   // Shift the strobe through the synchroniser and the edge-detect delay
   always_comb begin
      s1_d = async_in;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   // Synchroniser registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign rise = s2_q & ~s3_q;
endmodule

// File: rtl/sinhron_marker_gen.sv
// Frame/cycle marker generator aligned to an external sync strobe.
module sinhron_marker_gen
   import sinhron_pkg::*;
#(
   parameter int unsigned TICK_W = TICK_W_DEF,
   parameter int unsigned CYC_W  = CYC_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 sync_in,
   input  logic                 resync_en,
   sinhron_marker_gen_if.master bus
);
   logic rise;

   sinhron_state_e    state_q, state_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;

   logic [TICK_W-1:0] sh_cyc_len_q, sh_cyc_len_d;
   logic [CYC_W-1:0]  sh_n_cyc_q, sh_n_cyc_d;
   logic [TICK_W-1:0] sh_ti_start_q, sh_ti_start_d;
   logic [TICK_W-1:0] sh_ti_end_q, sh_ti_end_d;
   logic [TICK_W-1:0] sh_rp_start_q, sh_rp_start_d;
   logic [TICK_W-1:0] sh_rp_end_q, sh_rp_end_d;

   logic [MRK_NUM-1:0] mrk_q, mrk_d;
   logic               sync_err_q, sync_err_d;

   logic              load_cfg;
   logic [TICK_W-1:0] tick_last;
   logic [CYC_W-1:0]  cyc_last;
   logic              tick_wrap;
   logic              frame_wrap;

   sinhron_sync_edge u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (sync_in),
      .rise     (rise)
   );

   // A cycle shorter than 2 ticks runs as 2 ticks
   assign tick_last  = (sh_cyc_len_q < TICK_W'(2)) ? TICK_W'(1) : sh_cyc_len_q - TICK_W'(1);
   assign cyc_last   = sh_n_cyc_q - CYC_W'(1);
   assign tick_wrap  = (tick_q == tick_last);
   assign frame_wrap = tick_wrap && (cyc_q == cyc_last);

   // Next state, counter advance, sticky error and marker decode
   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      cyc_d      = cyc_q;
      sync_err_d = sync_err_q;
      load_cfg   = 1'b0;
      mrk_d      = '0;
      if (!enable) begin
         state_d    = ST_IDLE;
         tick_d     = '0;
         cyc_d      = '0;
         sync_err_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: state_d = ST_ARMED;
            ST_ARMED: begin
               if (rise) begin
                  state_d  = ST_RUN;
                  tick_d   = '0;
                  cyc_d    = '0;
                  load_cfg = 1'b1;
               end
            end
            ST_RUN: begin
               mrk_d[MRK_TNC]  = (tick_q == '0);
               mrk_d[MRK_TNO]  = (tick_q == '0) && (cyc_q == '0);
               mrk_d[MRK_TNI]  = (tick_q == sh_ti_start_q);
               mrk_d[MRK_TKI]  = (tick_q == sh_ti_end_q);
               mrk_d[MRK_TNP]  = (tick_q == sh_rp_start_q);
               mrk_d[MRK_TKP]  = (tick_q == sh_rp_end_q);
               mrk_d[MRK_TOBM] = frame_wrap;
               // A sync edge is only legal exactly on a frame wrap
               if (rise && !frame_wrap) begin
                  sync_err_d = 1'b1;
               end
               if (frame_wrap || (rise && resync_en)) begin
                  tick_d   = '0;
                  cyc_d    = '0;
                  load_cfg = 1'b1;
               end else if (tick_wrap) begin
                  tick_d = '0;
                  cyc_d  = cyc_q + CYC_W'(1);
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Shadow configuration: captured only at frame start
   always_comb begin
      sh_cyc_len_d  = sh_cyc_len_q;
      sh_n_cyc_d    = sh_n_cyc_q;
      sh_ti_start_d = sh_ti_start_q;
      sh_ti_end_d   = sh_ti_end_q;
      sh_rp_start_d = sh_rp_start_q;
      sh_rp_end_d   = sh_rp_end_q;
      if (load_cfg) begin
         sh_cyc_len_d  = bus.cyc_len;
         sh_n_cyc_d    = bus.n_cyc;
         sh_ti_start_d = bus.ti_start;
         sh_ti_end_d   = bus.ti_end;
         sh_rp_start_d = bus.rp_start;
         sh_rp_end_d   = bus.rp_end;
      end
   end

   // Control state and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tick_q     <= '0;
         cyc_q      <= '0;
         sync_err_q <= 1'b0;
         mrk_q      <= '0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         cyc_q      <= cyc_d;
         sync_err_q <= sync_err_d;
         mrk_q      <= mrk_d;
      end
   end

   // Shadow configuration registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_cyc_len_q  <= '0;
         sh_n_cyc_q    <= '0;
         sh_ti_start_q <= '0;
         sh_ti_end_q   <= '0;
         sh_rp_start_q <= '0;
         sh_rp_end_q   <= '0;
      end else begin
         sh_cyc_len_q  <= sh_cyc_len_d;
         sh_n_cyc_q    <= sh_n_cyc_d;
         sh_ti_start_q <= sh_ti_start_d;
         sh_ti_end_q   <= sh_ti_end_d;
         sh_rp_start_q <= sh_rp_start_d;
         sh_rp_end_q   <= sh_rp_end_d;
      end
   end

   assign bus.TNO      = mrk_q[MRK_TNO];
   assign bus.TNC      = mrk_q[MRK_TNC];
   assign bus.TNI      = mrk_q[MRK_TNI];
   assign bus.TKI      = mrk_q[MRK_TKI];
   assign bus.TNP      = mrk_q[MRK_TNP];
   assign bus.TKP      = mrk_q[MRK_TKP];
   assign bus.TOBM     = mrk_q[MRK_TOBM];
   assign bus.running  = (state_q == ST_RUN);
   assign bus.sync_err = sync_err_q;
endmodule

// File: tb/tb_sinhron_marker_gen.sv
// Bench for sinhron_marker_gen: directed scenarios plus random traffic,
// checked against a frame-position reference model.
module tb_sinhron_marker_gen;
   localparam int unsigned TW = 16;
   localparam int unsigned CW = 8;

   logic clk = 1'b0;
   logic rst;
   logic enable;
   logic sync_in;
   logic resync_en;

   sinhron_marker_gen_if #(.TICK_W(TW), .CYC_W(CW)) bus ();

   sinhron_marker_gen #(.TICK_W(TW), .CYC_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .sync_in   (sync_in),
      .resync_en (resync_en),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned cyc_no = 0;
   int unsigned tno_q[$];
   int unsigned last_tno, cl, c_tni, c_tki, c_tno, c_tnc;

   // Reference model: position inside the frame, modes 0 idle / 1 armed / 2 run
   int unsigned m_mode, m_pos, m_len, m_n, m_ti_s, m_ti_e, m_rp_s, m_rp_e;
   bit          m_s1, m_s2, m_s3, m_err;
   logic [8:0]  m_out;

   function automatic logic [8:0] dut_out();
      return {bus.running, bus.sync_err, bus.TOBM, bus.TKP, bus.TNP,
              bus.TKI, bus.TNI, bus.TNC, bus.TNO};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc_no, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_len = 2; m_n = 1;
      m_ti_s = 0; m_ti_e = 0; m_rp_s = 0; m_rp_e = 0;
      m_s1 = 0; m_s2 = 0; m_s3 = 0; m_err = 0;
      m_out = '0;
   endtask

   task automatic model_load();
      m_len  = (bus.cyc_len < 2) ? 2 : int'(bus.cyc_len);
      m_n    = (bus.n_cyc == 0) ? 256 : int'(bus.n_cyc);
      m_ti_s = bus.ti_start;
      m_ti_e = bus.ti_end;
      m_rp_s = bus.rp_start;
      m_rp_e = bus.rp_end;
   endtask

   task automatic model_step();
      bit          rise, fwrap;
      int unsigned tk;
      logic [6:0]  mk;
      rise  = m_s2 && !m_s3;
      fwrap = (m_mode == 2) && (m_pos == m_len * m_n - 1);
      tk    = m_pos % m_len;
      mk    = '0;
      if (enable && m_mode == 2) begin
         mk[0] = (m_pos == 0);
         mk[1] = (tk == 0);
         mk[2] = (tk == m_ti_s);
         mk[3] = (tk == m_ti_e);
         mk[4] = (tk == m_rp_s);
         mk[5] = (tk == m_rp_e);
         mk[6] = fwrap;
      end
      if (!enable) m_err = 0;
      else if (m_mode == 2 && rise && !fwrap) m_err = 1;
      if (!enable) begin
         m_mode = 0; m_pos = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (rise) begin m_mode = 2; m_pos = 0; model_load(); end
      end else if (fwrap || (rise && resync_en)) begin
         m_pos = 0; model_load();
      end else begin
         m_pos++;
      end
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = sync_in;
      m_out = {(m_mode == 2), m_err, mk[6], mk[5], mk[4], mk[3], mk[2], mk[1], mk[0]};
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      cyc_no++;
      #1;
      check("outs", 32'(dut_out()), 32'(m_out));
      if (bus.TNO === 1'b1) tno_q.push_back(cyc_no);
   endtask

   task automatic steps(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step();
   endtask

   task automatic wait_pos(input int unsigned target);
      for (int unsigned i = 0; i < 200 && !(m_mode == 2 && m_pos == target); i++) step();
      check("reach_pos", m_pos, target);
   endtask

   // Raise sync_in and count clocks until TNO appears
   task automatic sync_latency(input string tag);
      int unsigned n;
      n = 0;
      sync_in = 1'b1;
      do begin step(); n++; end while (bus.TNO !== 1'b1 && n < 12);
      check(tag, n, 4);
   endtask

   function automatic int unsigned period(input int unsigned k);
      return (tno_q.size() > k) ? tno_q[k] - tno_q[k-1] : 0;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; enable = 1'b0; sync_in = 1'b0; resync_en = 1'b0;
      bus.cyc_len = 16'd10; bus.n_cyc = 8'd3;
      bus.ti_start = 16'd2; bus.ti_end = 16'd5;
      bus.rp_start = 16'd6; bus.rp_end = 16'd8;
      model_reset();
      #12;
      check("reset_outs", 32'(dut_out()), 32'd0);
      rst = 1'b0;

      // Basic framing
      enable = 1'b1;
      steps(3);
      tno_q.delete();
      sync_latency("lat_first");
      steps(70);
      check("tno_period_30", period(1), 30);

      // Mid-frame cycle length change takes effect at next frame
      wait_pos(14);
      last_tno = (tno_q.size() > 0) ? tno_q[tno_q.size()-1] : 0;
      bus.cyc_len = 16'd12;
      tno_q.delete();
      tno_q.push_back(last_tno);
      steps(90);
      check("frame_keeps_30", period(1), 30);
      check("new_period_36a", period(2), 36);
      check("new_period_36b", period(3), 36);

      // Resync off a frame boundary
      resync_en = 1'b1;
      sync_in = 1'b0;
      steps(3);
      wait_pos(13);
      sync_latency("lat_resync");
      check("sync_err_set", 32'(bus.sync_err), 32'd1);
      steps(40);

      // Clear error, rearm, resync exactly on a frame wrap
      sync_in = 1'b0;
      enable = 1'b0;
      step();
      check("err_cleared", 32'(bus.sync_err), 32'd0);
      enable = 1'b1;
      steps(3);
      sync_latency("lat_rearm");
      sync_in = 1'b0;
      wait_pos(33);
      sync_latency("lat_aligned");
      steps(10);
      check("sync_err_aligned", 32'(bus.sync_err), 32'd0);

      // Offset beyond cycle length, one cycle per frame
      bus.ti_start = 16'd15; bus.cyc_len = 16'd10; bus.n_cyc = 8'd1;
      steps(40);
      c_tni = 0; c_tki = 0; c_tno = 0; c_tnc = 0;
      for (int unsigned i = 0; i < 30; i++) begin
         step();
         c_tni += int'(bus.TNI === 1'b1);
         c_tki += int'(bus.TKI === 1'b1);
         c_tno += int'(bus.TNO === 1'b1);
         c_tnc += int'(bus.TNC === 1'b1);
      end
      check("tni_never", c_tni, 0);
      check("tki_count", c_tki, 3);
      check("tno_count", c_tno, 3);
      check("tnc_count", c_tnc, 3);

      // Asynchronous reset mid-frame
      wait_pos(7);
      rst = 1'b1;
      #1;
      check("rst_async", 32'(dut_out()), 32'd0);
      enable = 1'b0;
      sync_in = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      model_reset();
      steps(6);
      enable = 1'b1;
      steps(8);
      check("idle_no_run", 32'(bus.running), 32'd0);
      sync_in = 1'b0;
      steps(3);
      sync_latency("lat_after_rst");

      // Disable mid-frame, then re-enable
      wait_pos(5);
      enable = 1'b0;
      step();
      check("dis_stop", 32'(dut_out()), 32'd0);
      enable = 1'b1;
      steps(10);
      check("armed_wait", 32'(bus.running), 32'd0);
      sync_in = 1'b0;
      steps(3);
      sync_latency("lat_reenable");

      // Random configuration, sync and enable traffic
      for (int unsigned i = 0; i < 320; i++) begin
         if (i % 40 == 0) begin
            cl = $urandom_range(9, 0);
            bus.cyc_len  = 16'(cl);
            bus.n_cyc    = 8'($urandom_range(4, 1));
            bus.ti_start = 16'($urandom_range(cl + 3, 0));
            bus.ti_end   = 16'($urandom_range(cl + 3, 0));
            bus.rp_start = 16'($urandom_range(cl + 3, 0));
            bus.rp_end   = 16'($urandom_range(cl + 3, 0));
            resync_en    = 1'($urandom_range(1, 0));
         end
         if ($urandom_range(7, 0) == 0) sync_in = ~sync_in;
         enable = ($urandom_range(59, 0) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
